btn_press_classifier: RTL and testbench
=======================================

Name: btn_press_classifier

Overview:
- Sits directly downstream of the three-sample button debouncer and runs on the same slow debounce clock `cclk`.
- Takes the debounced button level and turns it into single-cycle event pulses: short press, long press and auto-repeat while held.
- Also provides a held flag and a wrapping press counter for the display/control logic.
- All outputs are registered.

Parameters:
- LONG_CYC, 64, number of `cclk` cycles the button must stay high after the press edge to qualify as a long press (≥2).
- REPEAT_CYC, 16, `cclk` cycles between repeat pulses once the long press is reached (≥2).
- REPEAT_EN, 1, 1 = generate repeat pulses while long-held; 0 = never.
- CNT_W, 8, width of `hold_cnt`/`rpt_cnt`; must satisfy 2^CNT_W > max(LONG_CYC, REPEAT_CYC).

Ports:
- cclk  input  1  debounce-domain clock, all logic on its rising edge
- clr_n  input  1  asynchronous active-low reset
- btn_lvl  input  1  debounced button level from the debouncer stage, synchronous to `cclk`
- short_pulse  output  1  one-cycle pulse: button released before the long threshold
- long_pulse  output  1  one-cycle pulse: long threshold reached while still held
- repeat_pulse  output  1  one-cycle pulse every REPEAT_CYC cycles while long-held
- held  output  1  high while the FSM is in PRESS or LONG
- press_count  output  8  count of short plus long events, wraps 255→0

Behaviour:
- One clock, `cclk`. Reset is asynchronous and active-low on `clr_n`.
- Reset (`clr_n`=0, asynchronous, at any time including mid-press):
  - state=IDLE; `hold_cnt`, `rpt_cnt` and `press_count` = 0.
  - All pulse outputs and `held` = 0.
  - `btn_q` (previous-level flop) = 1, so a button held through reset is ignored until it is released and pressed again.
- Edge detect: rise = `btn_lvl` & ~`btn_q`; `btn_q` <= `btn_lvl` every cycle.
- FSM states: IDLE, PRESS, LONG. Pulse outputs default to 0 each cycle and are high for exactly one cycle.
- IDLE:
  - On rise at edge k → PRESS, `hold_cnt` <= 0.
  - `held` is 1 after edge k.
- PRESS:
  - If `btn_lvl`=0 → IDLE, `short_pulse` <= 1, `press_count` +1. Release is checked first.
  - Else if `hold_cnt`==LONG_CYC-1 → LONG, `long_pulse` <= 1, `press_count` +1, `rpt_cnt` <= 0.
  - Else `hold_cnt` +1.
  - Net effect: press at edge k, still high at edge k+LONG_CYC → `long_pulse` high after edge k+LONG_CYC.
  - Release sampled at any edge k+j with 1≤j≤LONG_CYC → `short_pulse` after that edge.
  - Release on the same edge the threshold would fire → short wins.
- LONG:
  - If `btn_lvl`=0 → IDLE, no pulse.
  - Else if REPEAT_EN and `rpt_cnt`==REPEAT_CYC-1 → `repeat_pulse` <= 1, `rpt_cnt` <= 0.
  - Else `rpt_cnt` +1. With REPEAT_EN=0, `rpt_cnt` holds at 0.
  - First repeat appears REPEAT_CYC cycles after `long_pulse`; repeats do not change `press_count`.
- `held` <= 1 when the next state is PRESS or LONG.
- Re-press in the cycle immediately after release: IDLE sees the rise and enters PRESS normally. Back-to-back presses are never lost.
- `press_count`: 8-bit unsigned, wraps 255→0 with no flag.
- Counters never exceed their terminal value. No X propagation from `btn_lvl` is required handling; the input is already debounced.

Decomposition:
- Shared package `btn_pkg`:
  - State encoding: IDLE=2'd0, PRESS=2'd1, LONG=2'd2; 2'd3 is illegal and recovers to IDLE.
  - Default LONG_CYC and REPEAT_CYC constants, shared with the top level and the bench.
- Optional sub-module `btn_rise_det` (`btn_q` flop with reset-to-1 plus rise output), reusable for other debounced inputs.
- FSM and counters stay in one module.

Test Plan (LONG_CYC=8, REPEAT_CYC=4, REPEAT_EN=1):
- Short press:
  - Stimulus: `btn_lvl` high 3 cycles then low.
  - Response: `short_pulse`=1 for exactly 1 cycle after the release edge; `long_pulse`=0; `press_count`=1; `held` high 3 cycles.
- Long hold with repeat:
  - Stimulus: `btn_lvl` high 20 cycles.
  - Response: `long_pulse` once, 8 cycles after the press edge; `repeat_pulse` at +4 and +8 after it (2 pulses); `short_pulse`=0 on release; `press_count`=1.
- Threshold tie:
  - Stimulus: release sampled exactly at edge k+8.
  - Response: `short_pulse`=1, `long_pulse`=0.
- Press through reset:
  - Stimulus: `btn_lvl`=1 while `clr_n` deasserts.
  - Response: no event and `held`=0 until `btn_lvl` goes low then high again.
  - Mid-press variant: assert `clr_n`=0 during LONG → all outputs 0 immediately (asynchronous).
- Wrap and back-to-back:
  - Stimulus: 256 short presses, each separated by a single low cycle.
  - Response: 256 `short_pulse`s; `press_count` reads 0 at the end (255→0 wrap).
- REPEAT_EN=0:
  - Stimulus: 20-cycle hold.
  - Response: one `long_pulse`, zero `repeat_pulse`s.

Source files
------------

// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
//   Shared definitions for the button press classifier.
//   - btn_state_t : classifier FSM encoding (IDLE=0, PRESS=1, LONG=2).
//                   Code 2'd3 is unused; the FSM recovers from it to IDLE.
//   - Default timing constants used by the top level.
//   - Helper that says whether a state counts as "button held".
// -----------------------------------------------------------------------------
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_LONG  = 2'd2
  } btn_state_t;

  // Default timing, in debounce-clock cycles.
  localparam int LONG_CYC_DEF   = 64;
  localparam int REPEAT_CYC_DEF = 16;

  // Width of the hold/repeat counters. Must hold max(LONG_CYC, REPEAT_CYC) - 1.
  localparam int CNT_W_DEF      = 8;

  // Width of the wrapping press counter.
  localparam int PRESS_CNT_W    = 8;

  // True for the states in which the button is considered held down.
  function automatic logic is_held_state(input btn_state_t s);
    return (s == ST_PRESS) || (s == ST_LONG);
  endfunction

endpackage

// File: rtl/btn_rise_det.sv
// -----------------------------------------------------------------------------
// btn_rise_det
//   Rising-edge detector for an already-debounced, clock-synchronous level.
//   The previous-level flop resets to 1, so an input that is already high
//   when reset is released does not produce a rise; it must go low and high
//   again first.
//
//   Ports
//     clk     in   clock, rising edge
//     rst_n   in   asynchronous active-low reset
//     i_lvl   in   debounced level
//     o_rise  out  combinational: i_lvl high now, low on the previous edge
// -----------------------------------------------------------------------------
module btn_rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_lvl,
  output logic o_rise
);

  logic r_lvl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lvl_q <= 1'b1;
    end else begin
      r_lvl_q <= i_lvl;
    end
  end

  assign o_rise = i_lvl & ~r_lvl_q;

endmodule

// File: rtl/btn_press_classifier.sv
// -----------------------------------------------------------------------------
// btn_press_classifier
//   Turns a debounced button level into single-cycle events:
//     short_pulse  - released before the long threshold
//     long_pulse   - still held LONG_CYC cycles after the press edge
//     repeat_pulse - every REPEAT_CYC cycles while long-held (REPEAT_EN=1)
//   plus a held flag and a wrapping count of short+long events.
//   All outputs are registered.
//
//   Valid/ready: there is no handshake. btn_lvl is sampled on every rising
//   cclk edge and each event pulse is valid for exactly one cycle; the
//   consumer must sample on every cycle (no backpressure).
//
//   Parameters
//     LONG_CYC   cycles held after the press edge for a long press (>= 2)
//     REPEAT_CYC cycles between repeat pulses once long-held        (>= 2)
//     REPEAT_EN  1 = generate repeat pulses, 0 = never
//     CNT_W      counter width, 2^CNT_W > max(LONG_CYC, REPEAT_CYC)
//
//   Ports
//     cclk          in   debounce-domain clock, rising edge
//     clr_n         in   asynchronous active-low reset
//     btn_lvl       in   debounced button level, synchronous to cclk
//     short_pulse   out  one-cycle short press event
//     long_pulse    out  one-cycle long press event
//     repeat_pulse  out  one-cycle auto-repeat event
//     held          out  high while the FSM is in PRESS or LONG
//     press_count   out  8-bit wrapping count of short + long events
//     dbg_state     out  current FSM state encoding (debug visibility)
// -----------------------------------------------------------------------------
module btn_press_classifier
  import btn_pkg::*;
#(
  parameter int LONG_CYC   = LONG_CYC_DEF,
  parameter int REPEAT_CYC = REPEAT_CYC_DEF,
  parameter bit REPEAT_EN  = 1'b1,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                   cclk,
  input  logic                   clr_n,
  input  logic                   btn_lvl,
  output logic                   short_pulse,
  output logic                   long_pulse,
  output logic                   repeat_pulse,
  output logic                   held,
  output logic [PRESS_CNT_W-1:0] press_count,
  output logic [1:0]             dbg_state
);

  // Terminal counter values. The hold counter starts at 0 on the press edge,
  // so reaching LONG_CYC-1 means the next high sample is edge k+LONG_CYC.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PRESS_CNT_W-1:0] PRESS_ONE = PRESS_CNT_W'(1);

  btn_state_t             r_state;
  logic [CNT_W-1:0]       r_hold_cnt;
  logic [CNT_W-1:0]       r_rpt_cnt;
  logic [PRESS_CNT_W-1:0] r_press_count;
  logic                   r_short;
  logic                   r_long;
  logic                   r_rpt;
  logic                   r_held;
  logic                   w_rise;

  btn_rise_det u_rise_det (
    .clk    (cclk),
    .rst_n  (clr_n),
    .i_lvl  (btn_lvl),
    .o_rise (w_rise)
  );

  always_ff @(posedge cclk or negedge clr_n) begin
    if (!clr_n) begin
      r_state       <= ST_IDLE;
      r_hold_cnt    <= '0;
      r_rpt_cnt     <= '0;
      r_press_count <= '0;
      r_short       <= 1'b0;
      r_long        <= 1'b0;
      r_rpt         <= 1'b0;
      r_held        <= 1'b0;
    end else begin
      // Event outputs are single-cycle: cleared unless set below.
      r_short <= 1'b0;
      r_long  <= 1'b0;
      r_rpt   <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_state    <= ST_PRESS;
            r_hold_cnt <= '0;
            r_held     <= 1'b1;
          end else begin
            r_held     <= 1'b0;
          end
        end

        ST_PRESS: begin
          // Release is tested before the threshold so that a release on the
          // threshold edge is still classified as a short press.
          if (!btn_lvl) begin
            r_state       <= ST_IDLE;
            r_short       <= 1'b1;
            r_press_count <= r_press_count + PRESS_ONE;
            r_held        <= 1'b0;
          end else if (r_hold_cnt == HOLD_LAST) begin
            r_state       <= ST_LONG;
            r_long        <= 1'b1;
            r_press_count <= r_press_count + PRESS_ONE;
            r_rpt_cnt     <= '0;
            r_held        <= 1'b1;
          end else begin
            r_hold_cnt    <= r_hold_cnt + CNT_ONE;
            r_held        <= 1'b1;
          end
        end

        ST_LONG: begin
          if (!btn_lvl) begin
            r_state <= ST_IDLE;
            r_held  <= 1'b0;
          end else begin
            r_held <= 1'b1;
            if (REPEAT_EN && (r_rpt_cnt == RPT_LAST)) begin
              r_rpt     <= 1'b1;
              r_rpt_cnt <= '0;
            end else if (REPEAT_EN) begin
              r_rpt_cnt <= r_rpt_cnt + CNT_ONE;
            end
            // With repeat disabled the counter simply stays at 0.
          end
        end

        default: begin
          // Unused encoding: fall back to a clean idle.
          r_state    <= ST_IDLE;
          r_hold_cnt <= '0;
          r_rpt_cnt  <= '0;
          r_held     <= 1'b0;
        end
      endcase
    end
  end

  assign short_pulse  = r_short;
  assign long_pulse   = r_long;
  assign repeat_pulse = r_rpt;
  assign held         = r_held;
  assign press_count  = r_press_count;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_btn_press_classifier.sv
// -----------------------------------------------------------------------------
// tb_btn_press_classifier
//   Two classifiers with LONG_CYC=8, REPEAT_CYC=4 share clock, reset and
//   button input: u_dut has repeat enabled, u_dut_nr has it disabled.
//   Expected outputs come from a press-age model: how many edges the button
//   has been held since the press edge decides short / long / repeat.
// -----------------------------------------------------------------------------
module tb_btn_press_classifier;
  import btn_pkg::*;

  localparam int LONG = 8;
  localparam int RPT  = 4;

  // ---------------- clock / reset ----------------
  logic cclk    = 1'b0;
  logic clr_n   = 1'b1;
  logic btn_lvl = 1'b0;

  always #5 cclk = ~cclk;

  logic       short_pulse, long_pulse, repeat_pulse, held;
  logic [7:0] press_count;
  logic [1:0] dbg_state;
  logic       short_pulse_nr, long_pulse_nr, repeat_pulse_nr, held_nr;
  logic [7:0] press_count_nr;
  logic [1:0] dbg_state_nr;

  btn_press_classifier #(
    .LONG_CYC(LONG), .REPEAT_CYC(RPT), .REPEAT_EN(1'b1), .CNT_W(8)
  ) u_dut (
    .cclk(cclk), .clr_n(clr_n), .btn_lvl(btn_lvl),
    .short_pulse(short_pulse), .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse), .held(held),
    .press_count(press_count), .dbg_state(dbg_state)
  );

  btn_press_classifier #(
    .LONG_CYC(LONG), .REPEAT_CYC(RPT), .REPEAT_EN(1'b0), .CNT_W(8)
  ) u_dut_nr (
    .cclk(cclk), .clr_n(clr_n), .btn_lvl(btn_lvl),
    .short_pulse(short_pulse_nr), .long_pulse(long_pulse_nr),
    .repeat_pulse(repeat_pulse_nr), .held(held_nr),
    .press_count(press_count_nr), .dbg_state(dbg_state_nr)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  // Expected {short, long, repeat, held, press_count[7:0]} after each edge.
  logic [11:0] exp_q[$];
  logic [11:0] exp_nr_q[$];

  // Reference model state: previous sampled level, whether a press is in
  // progress, and how many edges have passed since the press edge.
  logic       m_prev;
  logic       m_pressed;
  int         m_age;
  logic [7:0] m_count;

  function automatic logic [11:0] obs_main();
    return {short_pulse, long_pulse, repeat_pulse, held, press_count};
  endfunction

  function automatic logic [11:0] obs_nr();
    return {short_pulse_nr, long_pulse_nr, repeat_pulse_nr, held_nr, press_count_nr};
  endfunction

  task automatic model_reset();
    m_prev    = 1'b1;
    m_pressed = 1'b0;
    m_age     = 0;
    m_count   = 8'd0;
    exp_q.delete();
    exp_nr_q.delete();
  endtask

  task automatic model_edge(input logic b);
    logic s, l, r;
    s = 1'b0; l = 1'b0; r = 1'b0;
    if (!m_pressed) begin
      if (b && !m_prev) begin
        m_pressed = 1'b1;
        m_age     = 0;
      end
    end else begin
      m_age = m_age + 1;
      if (!b) begin
        m_pressed = 1'b0;
        if (m_age <= LONG) s = 1'b1;
      end else if (m_age == LONG) begin
        l = 1'b1;
      end else if (m_age > LONG && ((m_age - LONG) % RPT) == 0) begin
        r = 1'b1;
      end
    end
    if (s || l) m_count = m_count + 8'd1;
    m_prev = b;
    exp_q.push_back({s, l, r, m_pressed, m_count});
    exp_nr_q.push_back({s, l, 1'b0, m_pressed, m_count});
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; applies one sample and returns at the next
  // falling edge, where outputs are stable.
  task automatic drive(input logic b);
    btn_lvl = b;
    @(posedge cclk);
    model_edge(b);
    @(negedge cclk);
  endtask

  task automatic pulse_reset();
    #1 clr_n = 1'b0;
    @(posedge cclk);
    @(negedge cclk);
    model_reset();
    clr_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [11:0] got;
    got = obs_main();
    n_checks++;
    if (got !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_main: got %h expected %h", got, 12'h000);
    end
    got = obs_nr();
    n_checks++;
    if (got !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_nr: got %h expected %h", got, 12'h000);
    end
  endtask

  task automatic test_short_press();
    logic        stim[$];
    logic [11:0] got, exp;
    int          n_s, n_l, n_h;
    logic [7:0]  start;
    stim = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    n_s = 0; n_l = 0; n_h = 0;
    start = m_count;
    foreach (stim[i]) begin
      drive(stim[i]);
      if (short_pulse) n_s++;
      if (long_pulse)  n_l++;
      if (held)        n_h++;
      got = obs_main(); exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL short_press cyc %0d: got %h expected %h", i, got, exp);
      end
      got = obs_nr(); exp = exp_nr_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL short_press_nr cyc %0d: got %h expected %h", i, got, exp);
      end
    end
    n_checks++;
    if (n_s != 1 || n_l != 0 || n_h != 3) begin
      n_fail++;
      $display("FAIL short_press_totals: short=%0d long=%0d held=%0d expected 1 0 3", n_s, n_l, n_h);
    end
    n_checks++;
    if (press_count !== start + 8'd1) begin
      n_fail++;
      $display("FAIL short_press_count: got %0d expected %0d", press_count, start + 8'd1);
    end
  endtask

  task automatic test_long_repeat();
    logic        stim[$];
    logic [11:0] got, exp;
    int          n_s, n_l, n_r, n_r_nr, n_l_nr, long_at;
    logic [7:0]  start;
    stim.delete();
    for (int i = 0; i < 20; i++) stim.push_back(1'b1);
    stim.push_back(1'b0);
    stim.push_back(1'b0);
    n_s = 0; n_l = 0; n_r = 0; n_r_nr = 0; n_l_nr = 0; long_at = -1;
    start = m_count;
    foreach (stim[i]) begin
      drive(stim[i]);
      if (short_pulse)     n_s++;
      if (long_pulse)      begin n_l++; long_at = i; end
      if (repeat_pulse)    n_r++;
      if (repeat_pulse_nr) n_r_nr++;
      if (long_pulse_nr)   n_l_nr++;
      got = obs_main(); exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL long_repeat cyc %0d: got %h expected %h", i, got, exp);
      end
      got = obs_nr(); exp = exp_nr_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL long_repeat_nr cyc %0d: got %h expected %h", i, got, exp);
      end
    end
    n_checks++;
    if (n_l != 1 || long_at != LONG || n_r != 2 || n_s != 0) begin
      n_fail++;
      $display("FAIL long_repeat_totals: long=%0d at=%0d rpt=%0d short=%0d expected 1 8 2 0",
               n_l, long_at, n_r, n_s);
    end
    n_checks++;
    if (n_l_nr != 1 || n_r_nr != 0) begin
      n_fail++;
      $display("FAIL repeat_disabled: long=%0d rpt=%0d expected 1 0", n_l_nr, n_r_nr);
    end
    n_checks++;
    if (press_count !== start + 8'd1) begin
      n_fail++;
      $display("FAIL long_repeat_count: got %0d expected %0d", press_count, start + 8'd1);
    end
  endtask

  task automatic test_threshold_tie();
    logic        stim[$];
    logic [11:0] got, exp;
    int          n_s, n_l;
    stim.delete();
    for (int i = 0; i < LONG; i++) stim.push_back(1'b1);
    stim.push_back(1'b0);
    n_s = 0; n_l = 0;
    foreach (stim[i]) begin
      drive(stim[i]);
      if (short_pulse) n_s++;
      if (long_pulse)  n_l++;
      got = obs_main(); exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL threshold_tie cyc %0d: got %h expected %h", i, got, exp);
      end
      got = obs_nr(); exp = exp_nr_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL threshold_tie_nr cyc %0d: got %h expected %h", i, got, exp);
      end
    end
    n_checks++;
    if (n_s != 1 || n_l != 0) begin
      n_fail++;
      $display("FAIL threshold_tie_totals: short=%0d long=%0d expected 1 0", n_s, n_l);
    end
  endtask

  task automatic test_reset_mid_press();
    logic        stim[$];
    logic [11:0] got, exp;
    int          n_ev, n_h_early;
    // Reach LONG first.
    for (int i = 0; i < LONG + 2; i++) begin
      drive(1'b1);
      void'(exp_q.pop_front());
      void'(exp_nr_q.pop_front());
    end
    #1 clr_n = 1'b0;
    #1;
    got = obs_main();
    n_checks++;
    if (got !== 12'h000) begin
      n_fail++;
      $display("FAIL async_reset_main: got %h expected %h", got, 12'h000);
    end
    got = obs_nr();
    n_checks++;
    if (got !== 12'h000) begin
      n_fail++;
      $display("FAIL async_reset_nr: got %h expected %h", got, 12'h000);
    end
    @(posedge cclk);
    @(negedge cclk);
    model_reset();
    clr_n = 1'b1;
    // Button stays high through reset release, then a fresh short press.
    stim.delete();
    for (int i = 0; i < 12; i++) stim.push_back(1'b1);
    stim.push_back(1'b0); stim.push_back(1'b1); stim.push_back(1'b1);
    stim.push_back(1'b0); stim.push_back(1'b0);
    n_ev = 0; n_h_early = 0;
    foreach (stim[i]) begin
      drive(stim[i]);
      if (short_pulse || long_pulse || repeat_pulse) n_ev++;
      if (i < 12 && held) n_h_early++;
      got = obs_main(); exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL press_thru_reset cyc %0d: got %h expected %h", i, got, exp);
      end
      got = obs_nr(); exp = exp_nr_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL press_thru_reset_nr cyc %0d: got %h expected %h", i, got, exp);
      end
    end
    n_checks++;
    if (n_ev != 1 || n_h_early != 0 || press_count !== 8'd1) begin
      n_fail++;
      $display("FAIL press_thru_reset_totals: events=%0d early_held=%0d count=%0d expected 1 0 1",
               n_ev, n_h_early, press_count);
    end
  endtask

  task automatic test_back_to_back_wrap();
    logic [11:0] got, exp;
    int          n_s;
    logic [7:0]  cnt_255;
    btn_lvl = 1'b0;
    pulse_reset();
    drive(1'b0);
    void'(exp_q.pop_front());
    void'(exp_nr_q.pop_front());
    n_s = 0;
    cnt_255 = 8'hxx;
    for (int i = 0; i < 512; i++) begin
      drive((i % 2) == 0);
      if (short_pulse) n_s++;
      if (i == 509) cnt_255 = press_count;
      got = obs_main(); exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL back_to_back cyc %0d: got %h expected %h", i, got, exp);
      end
      got = obs_nr(); exp = exp_nr_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL back_to_back_nr cyc %0d: got %h expected %h", i, got, exp);
      end
    end
    n_checks++;
    if (n_s != 256 || cnt_255 !== 8'd255 || press_count !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_totals: shorts=%0d count_at_255=%0d final=%0d expected 256 255 0",
               n_s, cnt_255, press_count);
    end
  endtask

  task automatic test_random();
    logic        stim[$];
    logic [11:0] got, exp;
    int          hi, lo, e_long, e_rpt, n_l, n_r;
    logic [7:0]  start;
    stim.delete();
    e_long = 0; e_rpt = 0;
    start = m_count;
    for (int p = 0; p < 40; p++) begin
      hi = $urandom_range(1, 16);
      lo = $urandom_range(1, 4);
      for (int i = 0; i < hi; i++) stim.push_back(1'b1);
      for (int i = 0; i < lo; i++) stim.push_back(1'b0);
      // A press held for hi samples is released at age hi.
      if (hi > LONG) begin
        e_long++;
        e_rpt += (hi - 1 - LONG) / RPT;
      end
    end
    n_l = 0; n_r = 0;
    foreach (stim[i]) begin
      drive(stim[i]);
      if (long_pulse)   n_l++;
      if (repeat_pulse) n_r++;
      got = obs_main(); exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h expected %h", i, got, exp);
      end
      got = obs_nr(); exp = exp_nr_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random_nr cyc %0d: got %h expected %h", i, got, exp);
      end
    end
    n_checks++;
    if (n_l != e_long || n_r != e_rpt || press_count !== start + 8'd40) begin
      n_fail++;
      $display("FAIL random_totals: long=%0d rpt=%0d count=%0d expected %0d %0d %0d",
               n_l, n_r, press_count, e_long, e_rpt, start + 8'd40);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    #1 clr_n = 1'b0;
    #2;
    test_reset();
    @(negedge cclk);
    model_reset();
    clr_n = 1'b1;

    test_short_press();
    test_long_repeat();
    test_threshold_tie();
    test_reset_mid_press();
    test_back_to_back_wrap();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
